// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1 slice (A1/B1/M/P/OPMODE regs, CE high) as a dot-product MAC engine.
// Optional pre-adder mode, (D+B)*A, is enabled by defining DSP_SEQ_PREADD_EN.
module dsp_mac_sequencer #(
  parameter int LEN_W = 8,
  parameter int P_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
`ifdef DSP_SEQ_PREADD_EN
  input  logic [17:0]      op_d,
`endif
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [17:0]      dsp_D,
  output logic [7:0]       dsp_OPMODE,
  input  logic [47:0]      dsp_P,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising CLK edge where valid and ready are
  // both high; valid holds its payload until that edge, ready never depends on valid.
  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  localparam int CW = (P_LAT < 1) ? 1 : $clog2(P_LAT + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(P_LAT);

  localparam logic [7:0] OPM_CLEAR = 8'h00;
  localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;
`ifdef DSP_SEQ_PREADD_EN
  localparam logic [7:0] OPM_FIRST = 8'b0001_0001;
  localparam logic [7:0] OPM_NEXT  = 8'b0001_1001;
`else
  localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
  localparam logic [7:0] OPM_NEXT  = 8'b0000_1001;
`endif

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] term_q, term_d;
  logic [CW-1:0]    drain_q, drain_d;
  logic [7:0]       opmode_q, opmode_d;
  logic             res_valid_q, res_valid_d;
  logic [47:0]      res_data_q, res_data_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      term_q      <= '0;
      drain_q     <= '0;
      opmode_q    <= OPM_CLEAR;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      term_q      <= term_d;
      drain_q     <= drain_d;
      opmode_q    <= opmode_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    term_d      = term_q;
    drain_d     = drain_q;
    opmode_d    = opmode_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    job_ready   = 1'b0;
    op_ready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          len_d   = job_len;
          term_d  = '0;
          drain_d = '0;
          if (job_len == '0) begin
            // Empty job: zero P so the drain captures a clean 0.
            opmode_d = OPM_CLEAR;
            state_d  = S_DRAIN;
          end else begin
            state_d = S_FEED;
          end
        end
      end
      S_FEED: begin
        op_ready = 1'b1;
        if (op_valid) begin
          // First term uses Z=0, which replaces any stale P from earlier jobs.
          opmode_d = (term_q == '0) ? OPM_FIRST : OPM_NEXT;
          if (term_q == len_q - LEN_W'(1)) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            term_d = term_q + LEN_W'(1);
          end
        end else begin
          opmode_d = OPM_HOLD;
        end
      end
      S_DRAIN: begin
        opmode_d = OPM_HOLD;
        if (drain_q == DRAIN_LAST) begin
          res_data_d  = dsp_P;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          drain_d = drain_q + CW'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dsp_A      = op_a;
  assign dsp_B      = op_b;
`ifdef DSP_SEQ_PREADD_EN
  assign dsp_D      = op_d;
`else
  assign dsp_D      = '0;
`endif
  assign dsp_OPMODE = opmode_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice, dot-product reference and result scoreboard.
module tb_dsp_mac_sequencer;

  localparam int LEN_W = 8;
  localparam int P_LAT = 2;
`ifdef DSP_SEQ_PREADD_EN
  localparam logic [7:0] OPM_FIRST = 8'h11;
  localparam logic [7:0] OPM_NEXT  = 8'h19;
`else
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_NEXT  = 8'h09;
`endif
  localparam logic [7:0] OPM_HOLD = 8'h08;

  logic             CLK, RST_N;
  logic             job_valid, job_ready;
  logic [LEN_W-1:0] job_len;
  logic             op_valid, op_ready;
  logic [17:0]      op_a, op_b, op_d;
  logic [17:0]      dsp_A, dsp_B, dsp_D;
  logic [7:0]       dsp_OPMODE;
  logic [47:0]      dsp_P;
  logic             res_valid, res_ready;
  logic [47:0]      res_data;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [47:0] exp_q[$];
  bit hold_rr = 1'b0;
  int ja[256], jb[256], jd[256], jbub[256];

  dsp_mac_sequencer #(.LEN_W(LEN_W), .P_LAT(P_LAT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
`ifdef DSP_SEQ_PREADD_EN
    .op_d(op_d),
`endif
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_D(dsp_D), .dsp_OPMODE(dsp_OPMODE),
    .dsp_P(dsp_P), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- product of one term, by definition ----------------
  function automatic logic [47:0] term_val(input longint a, input longint b, input longint d);
`ifdef DSP_SEQ_PREADD_EN
    return 48'((d + b) * a);
`else
    return 48'(a * b + 0 * d);
`endif
  endfunction

  // ---------------- behavioural slice: A1/B1/D1 -> M -> P, OPMODE registered ----------------
  bit signed [17:0] a1, b1, d1;
  bit        [47:0] m_r, p_r;
  bit        [7:0]  opm_r;
  always @(posedge CLK) begin
    a1    <= dsp_A;
    b1    <= dsp_B;
    d1    <= dsp_D;
    m_r   <= term_val(longint'(a1), longint'(b1), longint'(d1));
    opm_r <= dsp_OPMODE;
    p_r   <= ((opm_r[3:2] == 2'b10) ? p_r : 48'd0) + ((opm_r[1:0] == 2'b01) ? m_r : 48'd0);
  end
  assign dsp_P = p_r;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- result consumer with random backpressure ----------------
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1 res_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_wait = 1'b0;
  logic [47:0] prev_data = '0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_data", 64'(res_data), 64'(prev_data));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %0h expected none", res_data);
        end else begin
          chk("res_data", 64'(res_data), 64'(exp_q.pop_front()));
        end
      end
      prev_wait = res_valid && !res_ready;
      prev_data = res_data;
    end
  end

  // ---------------- driver tasks (entered #1 after a rising edge) ----------------
  task automatic start_job(input int n);
    job_valid = 1'b1;
    job_len   = LEN_W'(n);
    for (int k = 0; ; k++) begin
      @(negedge CLK);
      if (job_ready) break;
      if (k > 200) begin
        chk("job_ready_timeout", 64'(job_ready), 64'd1);
        break;
      end
    end
    @(posedge CLK);
    #1 job_valid = 1'b0;
  endtask

  task automatic bubble();
    op_valid = 1'b0;
    op_a = 18'($urandom);
    op_b = 18'($urandom);
    @(posedge CLK);
    #1 chk("opmode_bubble", 64'(dsp_OPMODE), 64'(OPM_HOLD));
  endtask

  task automatic feed_term(input int a, input int b, input int d, input bit first);
    op_valid = 1'b1;
    op_a = 18'(a);
    op_b = 18'(b);
    op_d = 18'(d);
    @(negedge CLK);
    chk("op_ready_feed", 64'(op_ready), 64'd1);
    @(posedge CLK);
    #1 op_valid = 1'b0;
    chk("opmode_term", 64'(dsp_OPMODE), 64'(first ? OPM_FIRST : OPM_NEXT));
  endtask

  task automatic run_job(input int n, input int hold);
    logic [47:0] exp;
    int edges;
    exp = '0;
    for (int i = 0; i < n; i++) exp += term_val(longint'(ja[i]), longint'(jb[i]), longint'(jd[i]));
    exp_q.push_back(exp);
    if (hold > 0) hold_rr = 1'b1;
    start_job(n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < jbub[i]; k++) bubble();
      feed_term(ja[i], jb[i], jd[i], i == 0);
    end
    // Operands offered while draining must be ignored.
    op_valid = 1'b1;
    op_a = 18'($urandom);
    op_b = 18'($urandom);
    edges = 0;
    forever begin
      @(posedge CLK);
      #1 edges++;
      if (edges == 1) chk("op_ready_drain", 64'(op_ready), 64'd0);
      if (res_valid || edges > 20) break;
    end
    op_valid = 1'b0;
    chk("latency", 64'(edges), 64'(P_LAT + 1));
    if (hold > 0) begin
      job_valid = 1'b1;
      job_len   = LEN_W'(3);
      for (int k = 0; k < hold; k++) begin
        @(posedge CLK);
        #1 chk("done_valid", 64'(res_valid), 64'd1);
        chk("done_data", 64'(res_data), 64'(exp));
        chk("job_ready_done", 64'(job_ready), 64'd0);
      end
      job_valid = 1'b0;
      hold_rr   = 1'b0;
    end
    for (int k = 0; ; k++) begin
      @(posedge CLK);
      #1;
      if (!res_valid) break;
      if (k > 100) begin
        chk("handshake_timeout", 64'(res_valid), 64'd0);
        break;
      end
    end
    chk("job_ready_after", 64'(job_ready), 64'd1);
  endtask

  task automatic set_term(input int i, input int a, input int b, input int d, input int bub);
    ja[i] = a;
    jb[i] = b;
    jd[i] = d;
    jbub[i] = bub;
  endtask

  function automatic int rnd_s(input int half);
    return int'($urandom_range(0, 2 * half - 1)) - half;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    RST_N = 1'b0;
    job_valid = 1'b0;
    job_len = '0;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    op_d = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("rst_job_ready", 64'(job_ready), 64'd1);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_opmode", 64'(dsp_OPMODE), 64'd0);

    // Reset in the middle of a job: no result may ever appear.
    start_job(5);
    feed_term(1, 1, 0, 1'b1);
    feed_term(2, 2, 0, 1'b0);
    @(negedge CLK) RST_N = 1'b0;
    #1 chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_opmode", 64'(dsp_OPMODE), 64'd0);
    chk("midrst_op_ready", 64'(op_ready), 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("post_rst_job_ready", 64'(job_ready), 64'd1);
    chk("post_rst_op_ready", 64'(op_ready), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      #1 chk("post_rst_no_result", 64'(res_valid), 64'd0);
    end

    // Directed jobs.
    set_term(0, 2, 3, 0, 0); set_term(1, 4, 5, 0, 0); set_term(2, -1, 6, 0, 0);
    run_job(3, 0);
    set_term(0, 10, 5, 0, 0); set_term(1, 7, 7, 0, 3);
    run_job(2, 0);
    run_job(0, 5);
    set_term(0, 3, 3, 0, 0);
    run_job(1, 0);
    set_term(0, 2, 2, 0, 0);
    run_job(1, 0);
`ifdef DSP_SEQ_PREADD_EN
    set_term(0, 2, 2, 10, 0);
    run_job(1, 0);
`endif

    // Random jobs.
    for (int j = 0; j < 25; j++) begin
      n = int'($urandom_range(0, 10));
      for (int i = 0; i < n; i++) begin
`ifdef DSP_SEQ_PREADD_EN
        set_term(i, rnd_s(131072), rnd_s(32768), rnd_s(32768),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
`else
        set_term(i, rnd_s(131072), rnd_s(131072), 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
`endif
      end
      run_job(n, (j % 8 == 3) ? 2 : 0);
    end

    // Longest job: no counter wrap allowed.
    for (int i = 0; i < 255; i++) set_term(i, rnd_s(131072), rnd_s(32768), rnd_s(32768), 0);
    run_job(255, 0);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge CLK);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
